// File: rtl/mac_post_adder.sv
// Two-stage signed multiply / post-add (X/Z mux) datapath with accumulator feedback.
// Optional MAC_SATURATE_EN clamps signed overflow of p instead of wrapping.
module mac_post_adder #(
  parameter int WIDTH_AB = 18,
  parameter int WIDTH_P  = 48
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic                in_valid,
  input  logic [WIDTH_AB-1:0] a,
  input  logic [WIDTH_AB-1:0] b,
  input  logic [WIDTH_P-1:0]  c,
  input  logic [4:0]          opmode,
  input  logic                cin,
  output logic [WIDTH_P-1:0]  p,
  output logic                carry_out,
  output logic                p_valid
);

  localparam int WM = 2 * WIDTH_AB;

  logic [WM-1:0]       a_ext_s;
  logic [WM-1:0]       b_ext_s;
  logic [WM-1:0]       mult_s;

  logic [WIDTH_AB-1:0] a_r;
  logic [WIDTH_AB-1:0] b_r;
  logic [WM-1:0]       m_r;
  logic [WIDTH_P-1:0]  c_r;
  logic [4:0]          opmode_r;
  logic                cin_r;
  logic                valid_r;

  logic [WIDTH_P-1:0]  p_r;
  logic                carry_r;
  logic                p_valid_r;

  logic [1:0]          x_sel_s;
  logic [1:0]          z_sel_s;
  logic                sub_s;
  logic [WIDTH_P-1:0]  x_s;
  logic [WIDTH_P-1:0]  z_s;
  logic [WIDTH_P:0]    raw_s;
  logic [WIDTH_P-1:0]  p_next_s;

  // Sign-extended operands so the truncated product is the exact signed result
  assign a_ext_s = {{WIDTH_AB{a[WIDTH_AB-1]}}, a};
  assign b_ext_s = {{WIDTH_AB{b[WIDTH_AB-1]}}, b};
  assign mult_s  = a_ext_s * b_ext_s;

  assign x_sel_s = opmode_r[1:0];
  assign z_sel_s = opmode_r[3:2];
  assign sub_s   = opmode_r[4];

  // Stage 1: product and operand/control capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r      <= {WIDTH_AB{1'b0}};
      b_r      <= {WIDTH_AB{1'b0}};
      m_r      <= {WM{1'b0}};
      c_r      <= {WIDTH_P{1'b0}};
      opmode_r <= 5'd0;
      cin_r    <= 1'b0;
      valid_r  <= 1'b0;
    end else if (ce) begin
      a_r      <= a;
      b_r      <= b;
      m_r      <= mult_s;
      c_r      <= c;
      opmode_r <= opmode;
      cin_r    <= cin;
      valid_r  <= in_valid;
    end
  end

  // X and Z operand multiplexers
  always_comb begin
    x_s = {WIDTH_P{1'b0}};
    z_s = {WIDTH_P{1'b0}};
    case (x_sel_s)
      2'd0:    x_s = {WIDTH_P{1'b0}};
      2'd1:    x_s = {{(WIDTH_P-WM){m_r[WM-1]}}, m_r};
      2'd2:    x_s = p_r;
      2'd3:    x_s = {{(WIDTH_P-WM){1'b0}}, a_r, b_r};
      default: x_s = {WIDTH_P{1'b0}};
    endcase
    case (z_sel_s)
      2'd0:    z_s = {WIDTH_P{1'b0}};
      2'd1:    z_s = $unsigned($signed(p_r) >>> 5'd17);
      2'd2:    z_s = p_r;
      2'd3:    z_s = c_r;
      default: z_s = {WIDTH_P{1'b0}};
    endcase
  end

  // Unsigned WIDTH_P+1 post-adder; the top bit is the carry (or borrow)
  always_comb begin
    raw_s = {(WIDTH_P+1){1'b0}};
    if (sub_s) begin
      raw_s = {1'b0, z_s} - {1'b0, x_s} - {{WIDTH_P{1'b0}}, cin_r};
    end else begin
      raw_s = {1'b0, z_s} + {1'b0, x_s} + {{WIDTH_P{1'b0}}, cin_r};
    end
  end

`ifdef MAC_SATURATE_EN
  logic [WIDTH_P+1:0] sum_ext_s;
  logic               ovf_s;

  // Signed sum two bits wider than p detects overflow of the WIDTH_P result
  always_comb begin
    sum_ext_s = {(WIDTH_P+2){1'b0}};
    if (sub_s) begin
      sum_ext_s = {{2{z_s[WIDTH_P-1]}}, z_s} - {{2{x_s[WIDTH_P-1]}}, x_s}
                  - {{(WIDTH_P+1){1'b0}}, cin_r};
    end else begin
      sum_ext_s = {{2{z_s[WIDTH_P-1]}}, z_s} + {{2{x_s[WIDTH_P-1]}}, x_s}
                  + {{(WIDTH_P+1){1'b0}}, cin_r};
    end
    ovf_s = (sum_ext_s[WIDTH_P+1] != sum_ext_s[WIDTH_P]) ||
            (sum_ext_s[WIDTH_P]   != sum_ext_s[WIDTH_P-1]);
    if (!ovf_s) begin
      p_next_s = raw_s[WIDTH_P-1:0];
    end else if (sum_ext_s[WIDTH_P+1]) begin
      p_next_s = {1'b1, {(WIDTH_P-1){1'b0}}};
    end else begin
      p_next_s = {1'b0, {(WIDTH_P-1){1'b1}}};
    end
  end
`else
  assign p_next_s = raw_s[WIDTH_P-1:0];
`endif

  // Stage 2: result register, holds while the stage-1 slot is empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_r       <= {WIDTH_P{1'b0}};
      carry_r   <= 1'b0;
      p_valid_r <= 1'b0;
    end else if (ce) begin
      p_valid_r <= valid_r;
      if (valid_r) begin
        p_r     <= p_next_s;
        carry_r <= raw_s[WIDTH_P];
      end
    end
  end

  assign p         = p_r;
  assign carry_out = carry_r;
  // A stalled pipeline never presents a result as new
  assign p_valid   = p_valid_r & ce;

endmodule

// File: tb/tb_mac_post_adder.sv
// Scoreboard bench for mac_post_adder: expected results are queued at drive time
// and matched (value, carry, arrival cycle) against what the DUT presents.
module tb_mac_post_adder;

  typedef struct {
    logic [47:0] p;
    logic        co;
    int          cyc;
  } res_t;

  localparam logic [4:0] OP_MUL  = 5'b0_00_01;
  localparam logic [4:0] OP_ACC  = 5'b0_10_01;
  localparam logic [4:0] OP_SUBC = 5'b1_11_01;
  localparam logic [4:0] OP_LOAD = 5'b0_11_00;
  localparam logic [4:0] OP_INC  = 5'b0_10_11;
  localparam logic [4:0] OP_DEC  = 5'b1_10_11;
  localparam logic [4:0] OP_SHR  = 5'b0_01_00;
  localparam logic [4:0] OP_CAT  = 5'b0_00_11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b1;
  logic        in_valid = 1'b0;
  logic [17:0] a = 18'd0;
  logic [17:0] b = 18'd0;
  logic [47:0] c = 48'd0;
  logic [4:0]  opmode = 5'd0;
  logic        cin = 1'b0;
  logic [47:0] p;
  logic        carry_out;
  logic        p_valid;

  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  res_t exp_q[$];
  res_t obs_q[$];
  res_t e, o;

  mac_post_adder #(.WIDTH_AB(18), .WIDTH_P(48)) dut (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid),
    .a(a), .b(b), .c(c), .opmode(opmode), .cin(cin),
    .p(p), .carry_out(carry_out), .p_valid(p_valid)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [17:0] av, input logic [17:0] bv,
                       input logic [47:0] cv, input logic [4:0] op, input logic ci);
    in_valid = v; a = av; b = bv; c = cv; opmode = op; cin = ci;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (p_valid === 1'b1) obs_q.push_back('{p: p, co: carry_out, cyc: cyc});
  endtask

  task automatic push_exp(input logic [47:0] pv, input logic co, input int lat);
    exp_q.push_back('{p: pv, co: co, cyc: cyc + lat});
  endtask

  task automatic idle(input int n);
    drive(1'b0, 18'd0, 18'd0, 48'd0, 5'd0, 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    compared++;
    if (p !== 48'd0 || carry_out !== 1'b0 || p_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset: p=%h co=%b v=%b, required 0/0/0", p, carry_out, p_valid);
    end
    rst = 1'b0;
    obs_q.delete();
    idle(1);
  endtask

  task automatic test_multiply();
    push_exp(48'hFFFF_FFFF_FFF1, 1'b0, 2);
    drive(1'b1, 18'd3, 18'h3FFFB, 48'd0, OP_MUL, 1'b0);
    tick();
    idle(4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compared++;
      if (obs_q.size() == 0) begin
        mismatched++; $display("FAIL multiply: no result, required p=%h", e.p);
      end else begin
        o = obs_q.pop_front();
        if (o.p !== e.p || o.co !== e.co || o.cyc !== e.cyc) begin
          mismatched++;
          $display("FAIL multiply: p=%h co=%b cyc=%0d, required p=%h co=%b cyc=%0d",
                   o.p, o.co, o.cyc, e.p, e.co, e.cyc);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    push_exp(48'd0, 1'b0, 2);
    drive(1'b1, 18'd0, 18'd0, 48'd0, OP_LOAD, 1'b0);
    tick();
    for (int i = 1; i <= 4; i++) begin
      push_exp(48'(14 * i), 1'b0, 2);
      drive(1'b1, 18'd2, 18'd7, 48'd0, OP_ACC, 1'b0);
      tick();
    end
    idle(4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compared++;
      if (obs_q.size() == 0) begin
        mismatched++; $display("FAIL accumulate: no result, required p=%h", e.p);
      end else begin
        o = obs_q.pop_front();
        if (o.p !== e.p || o.co !== e.co || o.cyc !== e.cyc) begin
          mismatched++;
          $display("FAIL accumulate: p=%h co=%b cyc=%0d, required p=%h co=%b cyc=%0d",
                   o.p, o.co, o.cyc, e.p, e.co, e.cyc);
        end
      end
    end
  endtask

  task automatic test_subtract();
    push_exp(48'hFFFF_FFFF_FFFF, 1'b1, 2);
    drive(1'b1, 18'd10, 18'd10, 48'd100, OP_SUBC, 1'b1);
    tick();
    idle(4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compared++;
      if (obs_q.size() == 0) begin
        mismatched++; $display("FAIL subtract: no result, required p=%h", e.p);
      end else begin
        o = obs_q.pop_front();
        if (o.p !== e.p || o.co !== e.co || o.cyc !== e.cyc) begin
          mismatched++;
          $display("FAIL subtract: p=%h co=%b cyc=%0d, required p=%h co=%b cyc=%0d",
                   o.p, o.co, o.cyc, e.p, e.co, e.cyc);
        end
      end
    end
  endtask

  task automatic test_overflow();
    push_exp(48'h7FFF_FFFF_FFFF, 1'b0, 2);
    drive(1'b1, 18'd0, 18'd0, 48'h7FFF_FFFF_FFFF, OP_LOAD, 1'b0);
    tick();
`ifdef MAC_SATURATE_EN
    push_exp(48'h7FFF_FFFF_FFFF, 1'b0, 2);
`else
    push_exp(48'h8000_0000_0000, 1'b0, 2);
`endif
    drive(1'b1, 18'd0, 18'd1, 48'd0, OP_INC, 1'b0);
    tick();
    push_exp(48'h8000_0000_0000, 1'b0, 2);
    drive(1'b1, 18'd0, 18'd0, 48'h8000_0000_0000, OP_LOAD, 1'b0);
    tick();
`ifdef MAC_SATURATE_EN
    push_exp(48'h8000_0000_0000, 1'b0, 2);
`else
    push_exp(48'h7FFF_FFFF_FFFF, 1'b0, 2);
`endif
    drive(1'b1, 18'd0, 18'd1, 48'd0, OP_DEC, 1'b0);
    tick();
    idle(4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compared++;
      if (obs_q.size() == 0) begin
        mismatched++; $display("FAIL overflow: no result, required p=%h", e.p);
      end else begin
        o = obs_q.pop_front();
        if (o.p !== e.p || o.co !== e.co || o.cyc !== e.cyc) begin
          mismatched++;
          $display("FAIL overflow: p=%h co=%b cyc=%0d, required p=%h co=%b cyc=%0d",
                   o.p, o.co, o.cyc, e.p, e.co, e.cyc);
        end
      end
    end
  endtask

  task automatic test_mux_paths();
    push_exp(48'hF000_0000_0000, 1'b0, 2);
    drive(1'b1, 18'd0, 18'd0, 48'hF000_0000_0000, OP_LOAD, 1'b0);
    tick();
    push_exp(48'hFFFF_F800_0000, 1'b0, 2);
    drive(1'b1, 18'd0, 18'd0, 48'd0, OP_SHR, 1'b0);
    tick();
    push_exp(48'h000F_FFFE_0000, 1'b0, 2);
    drive(1'b1, 18'h3FFFF, 18'h20000, 48'd0, OP_CAT, 1'b0);
    tick();
    idle(4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compared++;
      if (obs_q.size() == 0) begin
        mismatched++; $display("FAIL mux_paths: no result, required p=%h", e.p);
      end else begin
        o = obs_q.pop_front();
        if (o.p !== e.p || o.co !== e.co || o.cyc !== e.cyc) begin
          mismatched++;
          $display("FAIL mux_paths: p=%h co=%b cyc=%0d, required p=%h co=%b cyc=%0d",
                   o.p, o.co, o.cyc, e.p, e.co, e.cyc);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [17:0] av, bv;
    logic [47:0] cv, m48;
    logic [63:0] r;
    logic [48:0] sum;
    logic        ci;
    for (int i = 0; i < 10; i++) begin
      av  = 18'($urandom);
      bv  = 18'($urandom);
      r   = {$urandom(), $urandom()};
      cv  = {{7{r[40]}}, r[40:0]};
      ci  = r[63];
      m48 = {{30{av[17]}}, av} * {{30{bv[17]}}, bv};
      sum = {1'b0, cv} + {1'b0, m48} + {48'd0, ci};
      push_exp(sum[47:0], sum[48], 2);
      drive(1'b1, av, bv, cv, OP_SUBC & 5'b0_11_11, ci);
      tick();
    end
    idle(4);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compared++;
      if (obs_q.size() == 0) begin
        mismatched++; $display("FAIL random: no result, required p=%h", e.p);
      end else begin
        o = obs_q.pop_front();
        if (o.p !== e.p || o.co !== e.co || o.cyc !== e.cyc) begin
          mismatched++;
          $display("FAIL random: p=%h co=%b cyc=%0d, required p=%h co=%b cyc=%0d",
                   o.p, o.co, o.cyc, e.p, e.co, e.cyc);
        end
      end
    end
  endtask

  task automatic test_ce_reset();
    push_exp(48'd50, 1'b0, 2);
    drive(1'b1, 18'd0, 18'd0, 48'd50, OP_LOAD, 1'b0);
    tick();
    push_exp(48'd51, 1'b0, 5);
    drive(1'b1, 18'd1, 18'd1, 48'd0, OP_ACC, 1'b0);
    tick();
    ce = 1'b0;
    drive(1'b1, 18'd9, 18'd9, 48'd0, OP_ACC, 1'b0);
    #1;
    compared++;
    if (p_valid !== 1'b0) begin
      mismatched++; $display("FAIL ce_gate: p_valid=%b, required 0", p_valid);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      compared++;
      if (p !== 48'd50 || p_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL ce_hold: p=%h v=%b, required p=%h v=0", p, p_valid, 48'd50);
      end
    end
    ce = 1'b1;
    idle(1);
    idle(1);
    compared++;
    if (p !== 48'd51 || p_valid !== 1'b0) begin
      mismatched++; $display("FAIL idle_hold: p=%h v=%b, required p=%h v=0", p, p_valid, 48'd51);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compared++;
      if (obs_q.size() == 0) begin
        mismatched++; $display("FAIL ce_stream: no result, required p=%h", e.p);
      end else begin
        o = obs_q.pop_front();
        if (o.p !== e.p || o.co !== e.co || o.cyc !== e.cyc) begin
          mismatched++;
          $display("FAIL ce_stream: p=%h co=%b cyc=%0d, required p=%h co=%b cyc=%0d",
                   o.p, o.co, o.cyc, e.p, e.co, e.cyc);
        end
      end
    end
    drive(1'b1, 18'd0, 18'd0, 48'd999, OP_LOAD, 1'b0);
    tick();
    #2 rst = 1'b1;
    #1;
    compared++;
    if (p !== 48'd0 || carry_out !== 1'b0 || p_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL async_rst: p=%h co=%b v=%b, required 0/0/0", p, carry_out, p_valid);
    end
    drive(1'b0, 18'd0, 18'd0, 48'd0, 5'd0, 1'b0);
    #2 rst = 1'b0;
    idle(3);
    compared++;
    if (obs_q.size() != 0) begin
      mismatched++; $display("FAIL flushed: %0d results, required 0", obs_q.size());
      obs_q.delete();
    end
    push_exp(48'd7, 1'b0, 2);
    drive(1'b1, 18'd0, 18'd0, 48'd7, OP_LOAD, 1'b0);
    tick();
    idle(3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compared++;
      if (obs_q.size() == 0) begin
        mismatched++; $display("FAIL post_rst: no result, required p=%h", e.p);
      end else begin
        o = obs_q.pop_front();
        if (o.p !== e.p || o.co !== e.co || o.cyc !== e.cyc) begin
          mismatched++;
          $display("FAIL post_rst: p=%h co=%b cyc=%0d, required p=%h co=%b cyc=%0d",
                   o.p, o.co, o.cyc, e.p, e.co, e.cyc);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_multiply();
    test_back_to_back();
    test_subtract();
    test_overflow();
    test_mux_paths();
    test_random();
    test_ce_reset();
    compared++;
    if (obs_q.size() != 0) begin
      mismatched++; $display("FAIL stray: %0d unexpected results, required 0", obs_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
